// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The PARITY state is only reachable when UART_RCVR_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Clocks per oversample tick; integer truncation is intended.
    function automatic int calc_div(input int clkfreq, input int baud);
        return clkfreq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud16.sv
// Free-running 16x-baud tick generator: one-cycle pulse every DIV clocks.
module uart_baud16
    import uart_pkg::*;
#(
    parameter int CLKFREQ = 100_000_000,
    parameter int BAUD    = 9600
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = calc_div(CLKFREQ, BAUD);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_baud16: CLKFREQ/(BAUD*16) must be at least 2");
    end

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rcvr.sv
// 16x-oversampling 8N1 UART receiver with valid/ack byte handoff, framing and overrun flags.
// Define UART_RCVR_PARITY_EN for an even-parity bit after the data and a perr output.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int CLKFREQ = 100_000_000,
    parameter int BAUD    = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       ovf
`ifdef UART_RCVR_PARITY_EN
    ,
    output logic       perr
`endif
);

    localparam logic [3:0] TC_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TC_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BC_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RCVR_PARITY_EN
    localparam rx_state_t POST_DATA = PARITY;
`else
    localparam rx_state_t POST_DATA = STOP;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd_s;
    logic                   w_tick;

    rx_state_t              r_state, w_state_nxt;
    logic [3:0]             r_tcnt, w_tcnt_nxt;
    logic [2:0]             r_bcnt, w_bcnt_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_brk, w_brk_nxt;
    logic                   w_deliver;

    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovf;
`ifdef UART_RCVR_PARITY_EN
    logic                   r_pbad, w_pbad_nxt;
    logic                   r_perr;
`endif

    uart_baud16 #(
        .CLKFREQ (CLKFREQ),
        .BAUD    (BAUD)
    ) u_baud16 (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign w_rxd_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_brk   <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
            r_pbad  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_brk   <= w_brk_nxt;
`ifdef UART_RCVR_PARITY_EN
            r_pbad  <= w_pbad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_brk_nxt   = r_brk;
        w_deliver   = 1'b0;
`ifdef UART_RCVR_PARITY_EN
        w_pbad_nxt  = r_pbad;
`endif
        case (r_state)
            IDLE: begin
                if (w_tick && !w_rxd_s) begin
                    w_state_nxt = START;
                    w_tcnt_nxt  = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_tcnt == TC_MID) begin
                        if (w_rxd_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_tcnt_nxt  = '0;
                            w_bcnt_nxt  = '0;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                // tcnt wraps to 0 on the sample tick, keeping later samples at mid-bit
                if (w_tick) begin
                    w_tcnt_nxt = r_tcnt + 4'd1;
                    if (r_tcnt == TC_LAST) begin
                        w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        w_bcnt_nxt  = r_bcnt + 3'd1;
                        if (r_bcnt == BC_LAST) begin
                            w_state_nxt = POST_DATA;
                        end
                    end
                end
            end
`ifdef UART_RCVR_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_tcnt_nxt = r_tcnt + 4'd1;
                    if (r_tcnt == TC_LAST) begin
                        w_pbad_nxt  = ^{r_shift, w_rxd_s};
                        w_state_nxt = STOP;
                    end
                end
            end
`endif
            STOP: begin
                // A low stop bit parks here until the line idles so a break yields one byte
                if (r_brk) begin
                    if (w_rxd_s) begin
                        w_brk_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else if (w_tick) begin
                    w_tcnt_nxt = r_tcnt + 4'd1;
                    if (r_tcnt == TC_LAST) begin
                        w_deliver = 1'b1;
                        if (w_rxd_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_brk_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ack on the held byte takes priority, so a coincident delivery replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else if (w_deliver && (!r_valid || ack)) begin
            r_data  <= r_shift;
            r_ferr  <= !w_rxd_s;
            r_valid <= 1'b1;
            r_ovf   <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
            r_perr  <= r_pbad;
`endif
        end else if (w_deliver) begin
            r_ovf <= 1'b1;
        end else if (ack && r_valid) begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign ferr  = r_ferr;
    assign ovf   = r_ovf;
`ifdef UART_RCVR_PARITY_EN
    assign perr  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rcvr.sv
// Scoreboard bench for uart_rcvr at 16 MHz / 100 kbaud (160 clocks per bit).
module tb_uart_rcvr;

    localparam int CLKFREQ  = 16_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIVC     = 10;
    localparam int BIT_CLKS = 160;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic       ack   = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovf;
`ifdef UART_RCVR_PARITY_EN
    logic       perr;
    logic       tb_bad_par = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rise_cyc = 0;
    logic vld_d   = 1'b0;
    int   lat     = 0;

    uart_rcvr #(
        .CLKFREQ (CLKFREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .ack   (ack),
        .data  (data),
        .valid (valid),
        .ferr  (ferr),
        .ovf   (ovf)
`ifdef UART_RCVR_PARITY_EN
        ,
        .perr  (perr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        vld_d <= valid;
        if (valid === 1'b1 && vld_d !== 1'b1) rise_cyc <= cyc;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] obs();
`ifdef UART_RCVR_PARITY_EN
        return {data, ferr, perr};
`else
        return {data, ferr, 1'b0};
`endif
    endfunction

    // Frame starts on a tick-aligned cycle so delivery latency is repeatable.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len,
                              input int ack_at, input int abort_bits, output int start);
        logic [11:0] fr;
        int          nb;
        int          k;
        int          len;
`ifdef UART_RCVR_PARITY_EN
        fr = {1'b0, stop, (^d) ^ tb_bad_par, d, 1'b0};
        nb = 11;
`else
        fr = {2'b00, stop, d, 1'b0};
        nb = 10;
`endif
        while (cyc % DIVC != 0) step();
        start = cyc;
        k = 0;
        for (int b = 0; b < nb; b++) begin
            if (abort_bits != 0 && b == abort_bits) return;
            len = (b == nb - 1) ? stop_len : BIT_CLKS;
            for (int i = 0; i < len; i++) begin
                rxd = fr[b];
                ack = (k == ack_at);
                step();
                k++;
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        ack   = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({data, valid, ferr, ovf} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", {data, valid, ferr, ovf}, 11'b0);
        end
        rst_n = 1'b1;
        repeat (5) step();
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid got %b required 0", valid);
        end
    endtask

    task automatic test_good_frame();
        int   st;
        exp_t e;
        sb.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b1, BIT_CLKS, -1, 0, st);
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        n_tests++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_valid: got %b required 1", valid);
        end
        lat = rise_cyc - st;
        n_tests++;
        if (lat < 1510 || lat > 1545) begin
            n_fail++;
            $display("FAIL a5_latency: got %0d clocks required 1510..1545", lat);
        end
        e = sb.pop_front();
        n_tests++;
        if (obs() !== {e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL a5_byte: got %h required %h", obs(), {e.d, e.fe, e.pe});
        end
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_ovf: got %b required 0", ovf);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_ack_clear: valid got %b required 0", valid);
        end
    endtask

    task automatic test_false_start();
        int   st;
        exp_t e;
        rxd = 1'b0;
        repeat (40) step();
        rxd = 1'b1;
        repeat (3 * BIT_CLKS) step();
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_no_valid: valid got %b required 0", valid);
        end
        sb.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1, BIT_CLKS, -1, 0, st);
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        e = sb.pop_front();
        n_tests++;
        if ({valid, obs()} !== {1'b1, e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL after_glitch_byte: got %h required %h", {valid, obs()}, {1'b1, e.d, e.fe, e.pe});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_break();
        int   st;
        exp_t e;
        sb.push_back('{8'h81, 1'b1, 1'b0});
        send_frame(8'h81, 1'b0, 4 * BIT_CLKS, -1, 0, st);
        rxd = 1'b1;
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        e = sb.pop_front();
        n_tests++;
        if ({valid, obs()} !== {1'b1, e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL break_byte: got %h required %h", {valid, obs()}, {1'b1, e.d, e.fe, e.pe});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (8 * BIT_CLKS) step();
        n_tests++;
        if ({valid, ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL break_single_byte: valid/ovf got %b required 00", {valid, ovf});
        end
    endtask

    task automatic test_overrun();
        int   st;
        exp_t e;
        sb.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 1'b1, BIT_CLKS, -1, 0, st);
        send_frame(8'h22, 1'b1, BIT_CLKS, -1, 0, st);
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== {e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL overrun_keeps_first: got %h required %h", obs(), {e.d, e.fe, e.pe});
        end
        n_tests++;
        if ({valid, ovf} !== 2'b11) begin
            n_fail++;
            $display("FAIL overrun_flag: valid/ovf got %b required 11", {valid, ovf});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_tests++;
        if ({valid, ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL overrun_ack_clear: valid/ovf got %b required 00", {valid, ovf});
        end
    endtask

    task automatic test_ack_coincident();
        int   st;
        exp_t e;
        sb.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 1'b1, BIT_CLKS, -1, 0, st);
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        e = sb.pop_front();
        n_tests++;
        if ({valid, obs()} !== {1'b1, e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL coinc_first_byte: got %h required %h", {valid, obs()}, {1'b1, e.d, e.fe, e.pe});
        end
        sb.push_back('{8'h22, 1'b0, 1'b0});
        send_frame(8'h22, 1'b1, BIT_CLKS, lat - 1, 0, st);
        e = sb.pop_front();
        n_tests++;
        if ({valid, ovf, obs()} !== {2'b10, e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL coinc_replace: valid/ovf/byte got %h required %h",
                     {valid, ovf, obs()}, {2'b10, e.d, e.fe, e.pe});
        end
    endtask

    task automatic test_reset_abort();
        int   st;
        exp_t e;
        send_frame(8'h5A, 1'b1, BIT_CLKS, -1, 5, st);
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({data, valid, ferr, ovf} !== 11'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got %b required %b", {data, valid, ferr, ovf}, 11'b0);
        end
        rxd = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) step();
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_byte_lost: valid got %b required 0", valid);
        end
        sb.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b1, BIT_CLKS, -1, 0, st);
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        e = sb.pop_front();
        n_tests++;
        if ({valid, obs()} !== {1'b1, e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL post_reset_byte: got %h required %h", {valid, obs()}, {1'b1, e.d, e.fe, e.pe});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

`ifdef UART_RCVR_PARITY_EN
    task automatic test_parity();
        int   st;
        exp_t e;
        tb_bad_par = 1'b1;
        sb.push_back('{8'h07, 1'b0, 1'b1});
        send_frame(8'h07, 1'b1, BIT_CLKS, -1, 0, st);
        tb_bad_par = 1'b0;
        for (int i = 0; i < 400 && valid !== 1'b1; i++) step();
        e = sb.pop_front();
        n_tests++;
        if ({valid, obs()} !== {1'b1, e.d, e.fe, e.pe}) begin
            n_fail++;
            $display("FAIL parity_error: got %h required %h", {valid, obs()}, {1'b1, e.d, e.fe, e.pe});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_false_start();
        test_break();
        test_overrun();
        test_ack_coincident();
        test_reset_abort();
`ifdef UART_RCVR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
